div_unit_seq: RTL and testbench

Iterative radix-2 restoring divider for the RV32IM M-extension ops DIV, DIVU, REM and REMU. It sits beside the ALU in the execute stage. Decode hands it operands with a start pulse, and the core stalls on busy. The registered result feeds the writeback mux. It replaces the combinational divide path so the core's critical path shrinks.

---
 rtl/rv32im_pkg.sv | 34 +++
 rtl/div_step.sv | 28 ++
 rtl/div_unit_seq.sv | 175 +++++++++++++++++
 tb/tb_div_unit_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared types and constants for the RV32IM divide unit.
//   div_op_t    : funct3[1:0] encoding of DIV/DIVU/REM/REMU
//   div_state_t : divider sequencer states
//   XLEN        : default operand width
//   div_zero_quot / div_ovf_quot : RISC-V special-case quotient constants,
//                 returned 64 bits wide and sliced by the caller to its width.
package rv32im_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Quotient for x/0: all ones at width w.
  function automatic logic [63:0] div_zero_quot(input int unsigned w);
    return ~64'd0 >> (64 - w);
  endfunction

  // Quotient for -2^(w-1) / -1: the most negative value at width w.
  function automatic logic [63:0] div_ovf_quot(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   rem_i/dvd_i/dvs_i : partial remainder, shifting dividend, divisor
//   rem_o             : next partial remainder
//   dvd_o             : dividend shifted left by one (LSB zero)
//   q_bit_o           : quotient bit produced by this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o,
  output logic         q_bit_o
);

  // The shifted remainder carries one extra bit: with a divisor near 2^W the
  // partial remainder can exceed W bits for one step before the subtract.
  logic [W:0] rem_sh;

  always_comb begin
    rem_sh  = {rem_i, dvd_i[W-1]};
    q_bit_o = (rem_sh >= {1'b0, dvs_i});
    rem_o   = q_bit_o ? rem_sh[W-1:0] - dvs_i : rem_sh[W-1:0];
    dvd_o   = {dvd_i[W-2:0], 1'b0};
  end

endmodule

// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// Optional feature macro: DIV_EARLY_OUT_EN (divide-by-zero, signed overflow
// and dividend<divisor finish in two cycles instead of XLEN+2).
// Ports:
//   clk, reset      : rising-edge clock, async active-high reset
//   start, op       : launch request and funct3[1:0] operation
//   rs1_val/rs2_val : dividend / divisor
//   kill            : synchronous abort, wins over start
//   busy            : operation in flight
//   done            : one-cycle pulse, result valid
//   result          : quotient or remainder, held until next done
module div_unit_seq #(
  parameter int XLEN  = rv32im_pkg::XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv32im_pkg::*;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             sel_rem_q, sel_rem_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN-1:0]  step_rem, step_dvd;
  logic             step_q;

  logic             is_signed, s1, s2, dz;
  logic [XLEN-1:0]  a1, a2;

`ifdef DIV_EARLY_OUT_EN
  localparam logic [63:0] DZ_Q64  = div_zero_quot(XLEN);
  localparam logic [63:0] OVF_Q64 = div_ovf_quot(XLEN);
  logic ovf, lt;
`endif

  div_step #(.W(XLEN)) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .dvd_o  (step_dvd),
    .q_bit_o(step_q)
  );

  always_comb begin
    // Operand magnitudes; |-2^(XLEN-1)| wraps to itself, read as unsigned.
    is_signed = ~op[0];
    s1        = is_signed & rs1_val[XLEN-1];
    s2        = is_signed & rs2_val[XLEN-1];
    a1        = s1 ? -rs1_val : rs1_val;
    a2        = s2 ? -rs2_val : rs2_val;
    dz        = (rs2_val == '0);
`ifdef DIV_EARLY_OUT_EN
    ovf       = is_signed && (rs1_val == OVF_Q64[XLEN-1:0]) && (rs2_val == '1);
    lt        = !dz && (a1 < a2);
`endif

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = '0;
          dvd_d     = a1;
          dvs_d     = a2;
          quo_d     = '0;
          // Divide by zero: the restoring loop yields all-ones naturally,
          // so only suppress the quotient negation.
          q_neg_d   = (s1 ^ s2) & ~dz;
          r_neg_d   = s1;
          sel_rem_d = op[1];
          cnt_d     = CNT_W'(XLEN - 1);
          state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (dz) begin
            quo_d   = DZ_Q64[XLEN-1:0];
            rem_d   = a1;
            state_d = FIN;
          end else if (ovf) begin
            quo_d   = OVF_Q64[XLEN-1:0];
            q_neg_d = 1'b0;
            rem_d   = '0;
            state_d = FIN;
          end else if (lt) begin
            quo_d   = '0;
            rem_d   = a1;
            state_d = FIN;
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        quo_d = {quo_q[XLEN-2:0], step_q};
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIN: begin
        result_d = sel_rem_q ? (r_neg_q ? -rem_q : rem_q)
                             : (q_neg_q ? -quo_q : quo_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush: drop whatever is in flight, keep the last delivered result.
    if (kill) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sel_rem_q <= sel_rem_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
module tb_div_unit_seq;

  localparam int XLEN = 32;
  localparam int L    = XLEN + 2;
`ifdef DIV_EARLY_OUT_EN
  localparam int LE = 2;
`else
  localparam int LE = XLEN + 2;
`endif

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic            kill = 1'b0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
    string           name;
  } exp_t;
  exp_t sb[$];

  div_unit_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pops one expectation and checks value and arrival cycle.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cycle %0d result %h, required no done", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: result %h at cycle %0d, required %h at cycle %0d",
                   e.name, result, cyc, e.res, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the next posedge.
  task automatic issue(input string name, input logic [1:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                       input int lat, input bit push);
    exp_t e;
    start = 1'b1; op = o; rs1_val = a; rs2_val = b;
    if (push) begin
      e.res = exp; e.cyc = cyc + lat; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within 200 cycles, required done", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    issue(name, o, a, b, exp, lat, 1'b1);
    wait_done(name);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency profile plus back-to-back launch in the done cycle.
    chk("idle_busy", {31'd0, busy}, 0);
    n = cyc;
    issue("divu_100_7", DIVU, 100, 7, 14, L, 1'b1);
    chk("busy_n1", {31'd0, busy}, 1);
    repeat (32) begin @(posedge clk); #1; end
    chk("busy_n33", {31'd0, busy}, 1);
    @(posedge clk); #1;
    chk("busy_n34", {31'd0, busy}, 0);
    chk("done_n34", {31'd0, done}, 1);
    chk("cycle_n34", cyc - n, 34);
    issue("remu_100_7_b2b", REMU, 100, 7, 2, L, 1'b1);
    wait_done("remu_100_7_b2b");

    run("div_m20_3",   DIV,  32'hFFFFFFEC, 3,            32'hFFFFFFFA, L);
    run("rem_m20_3",   REM,  32'hFFFFFFEC, 3,            32'hFFFFFFFE, L);
    run("div_20_m3",   DIV,  20,           32'hFFFFFFFD, 32'hFFFFFFFA, L);
    run("rem_20_m3",   REM,  20,           32'hFFFFFFFD, 2,            L);
    run("div_m7_m2",   DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 3,            L);
    run("rem_m7_m2",   REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, L);
    run("divu_big",    DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 1,            L);
    run("remu_big",    REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 1,            L);
    run("divu_lt",     DIVU, 3,            10,           0,            LE);
    run("remu_lt",     REMU, 3,            10,           3,            LE);
    run("divu_5_0",    DIVU, 5,            0,            32'hFFFFFFFF, LE);
    run("div_5_0",     DIV,  5,            0,            32'hFFFFFFFF, LE);
    run("div_m20_0",   DIV,  32'hFFFFFFEC, 0,            32'hFFFFFFFF, LE);
    run("rem_5_0",     REM,  5,            0,            5,            LE);
    run("rem_m20_0",   REM,  32'hFFFFFFEC, 0,            32'hFFFFFFEC, LE);
    run("remu_min_0",  REMU, 32'h80000000, 0,            32'h80000000, LE);
    run("div_ovf",     DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, LE);
    run("rem_ovf",     REM,  32'h80000000, 32'hFFFFFFFF, 0,            LE);

    // kill mid-operation, then relaunch the cycle after.
    n = cyc;
    issue("killed", DIVU, 1000, 3, 0, L, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_cycle", cyc - n, 11);
    chk("kill_busy", {31'd0, busy}, 0);
    chk("kill_result", result, 0);
    issue("divu_9_2", DIVU, 9, 2, 4, L, 1'b1);
    wait_done("divu_9_2");

    // kill together with start in IDLE: nothing launches.
    start = 1'b1; kill = 1'b1; op = DIVU; rs1_val = 50; rs2_val = 5;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", {31'd0, busy}, 0);
    repeat (40) begin @(posedge clk); #1; end

    // Async reset mid-operation clears outputs immediately; no done follows.
    issue("reset_victim", DIVU, 77, 7, 0, L, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    chk("rst_mid_result", result, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    run("post_reset_divu", DIVU, 100, 7, 14, L);

    repeat (5) begin @(posedge clk); #1; end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
